// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce.
//
// Drives one keypad column low at a time. It reads the active-low row lines
// through a 2-flop synchronizer. A key is accepted once the same single row
// has stayed low for DEBOUNCE_TICKS scan ticks. The key is released once all
// rows have stayed high for DEBOUNCE_TICKS scan ticks. Patterns with zero or
// with two or more low rows are treated as "no key", which rejects ghosting.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   row[3:0]   keypad rows, active-low, asynchronous to clk
//   col[3:0]   column drive, active-low, exactly one bit low
//   key_code   last accepted key = row_idx*4 + col_idx
//   key_valid  one-clk strobe when key_code is (re)issued
//   key_held   high while the accepted key is still down
//
// Handshake: key_valid is a push-only strobe with no ready. The consumer must
// capture key_code on any clk edge where key_valid is high. key_code stays
// stable until the next strobe.
//
// Optional build macro KEYPAD_AUTOREPEAT_EN: while a key is held, key_valid
// re-pulses every REPEAT_TICKS scan ticks with the same key_code.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(SCAN_DIV - 1);
  // The debounce and release counters finish when they sit at N-1 on a
  // qualifying tick.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  // Row synchronizer. The flops reset to all-high, which means "no key".
  logic [3:0] row_meta;
  logic [3:0] rows_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta <= 4'hF;
      rows_s   <= 4'hF;
    end else begin
      row_meta <= row;
      rows_s   <= row_meta;
    end
  end

  // Scan tick divider.
  logic [CW-1:0] div_cnt;
  logic          tick;

  assign tick = (div_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

  // Row decode. "single" is true when exactly one row is low.
  logic [3:0] low;
  logic       single;
  logic       all_high;
  logic [1:0] hit_idx;

  assign low      = ~rows_s;
  assign single   = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign all_high = (rows_s == 4'hF);

  always_comb begin
    hit_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (low[i]) hit_idx = 2'(i);
    end
  end

  // FSM and datapath registers.
  state_t          state_q, state_n;
  logic [1:0]      col_idx_q, col_idx_n;
  logic [1:0]      row_idx_q, row_idx_n;
  logic [DW-1:0]   deb_q, deb_n;
  logic [DW-1:0]   rel_q, rel_n;
  logic [3:0]      code_q, code_n;
  logic            valid_q, valid_n;
  logic            accept;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_q, rep_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      col_idx_q <= 2'd0;
      row_idx_q <= 2'd0;
      deb_q     <= '0;
      rel_q     <= '0;
      code_q    <= 4'd0;
      valid_q   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_n;
      col_idx_q <= col_idx_n;
      row_idx_q <= row_idx_n;
      deb_q     <= deb_n;
      rel_q     <= rel_n;
      code_q    <= code_n;
      valid_q   <= valid_n;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= rep_n;
`endif
    end
  end

  always_comb begin
    state_n   = state_q;
    col_idx_n = col_idx_q;
    row_idx_n = row_idx_q;
    deb_n     = deb_q;
    rel_n     = rel_q;
    code_n    = code_q;
    valid_n   = 1'b0;
    accept    = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_n     = rep_q;
`endif

    if (tick) begin
      case (state_q)
        SCAN: begin
          if (single) begin
            row_idx_n = hit_idx;
            if (DEBOUNCE_TICKS == 1) begin
              accept = 1'b1;
            end else begin
              deb_n   = DW'(1);
              state_n = DEBOUNCE;
            end
          end else begin
            col_idx_n = col_idx_q + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (single && (hit_idx == row_idx_q)) begin
            if (deb_q == DEB_LAST) accept = 1'b1;
            else                   deb_n  = deb_q + DW'(1);
          end else begin
            // Column stays put on this tick. Scanning resumes on the next one.
            deb_n   = '0;
            state_n = SCAN;
          end
        end

        PRESSED: begin
          if (all_high) begin
            if (rel_q == DEB_LAST) begin
              rel_n     = '0;
              state_n   = SCAN;
              col_idx_n = col_idx_q + 2'd1;
            end else begin
              rel_n = rel_q + DW'(1);
            end
          end else begin
            rel_n = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (rep_q == REP_LAST) begin
              valid_n = 1'b1;
              rep_n   = '0;
            end else begin
              rep_n = rep_q + RW'(1);
            end
`endif
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (rel_n != '0) rep_n = '0;
`endif
        end

        default: state_n = SCAN;
      endcase

      if (accept) begin
        code_n  = {row_idx_n, col_idx_q};
        valid_n = 1'b1;
        state_n = PRESSED;
        deb_n   = '0;
        rel_n   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_n   = '0;
`endif
      end
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == PRESSED);

endmodule
